// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor, DIFF = X - Y - B_in, LSB first.
// Latency: DONE high in the cycle after edge k+WIDTH, where k is the edge that accepts START.
// Backpressure: START is ignored while BUSY; a START during the DONE cycle is accepted (back-to-back).
// Optional build macro SERIAL_SUB_OVF_EN adds the signed-overflow output OVF.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             B_in,
  output logic [WIDTH-1:0] DIFF,
  output logic             B_out,
  output logic             BUSY,
  output logic             DONE
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-2:0] r_sh;      // bits already produced; the newest bit enters at the top
  logic             borrow_ff;
  logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
  logic             borrow_msb; // borrow flowing into the MSB stage
`endif

  logic             x0, y0, d, new_borrow, last_bit;
  logic [WIDTH-1:0] res_next;

  // Single full-subtractor cell operating on the current LSBs.
  always_comb begin
    x0         = x_sh[0];
    y0         = y_sh[0];
    d          = x0 ^ y0 ^ borrow_ff;
    new_borrow = (~x0 & y0) | (~(x0 ^ y0) & borrow_ff);
    res_next   = {d, r_sh};
    last_bit   = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      x_sh      <= '0;
      y_sh      <= '0;
      r_sh      <= '0;
      borrow_ff <= 1'b0;
      cnt       <= '0;
      DIFF      <= '0;
      B_out     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      borrow_msb <= 1'b0;
      OVF        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FIN: begin
          DONE <= 1'b0;
          if (START) begin
            x_sh      <= X;
            y_sh      <= Y;
            borrow_ff <= B_in;
            r_sh      <= '0;
            cnt       <= '0;
            BUSY      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          x_sh      <= {1'b0, x_sh[WIDTH-1:1]};
          y_sh      <= {1'b0, y_sh[WIDTH-1:1]};
          r_sh      <= res_next[WIDTH-1:1];
          borrow_ff <= new_borrow;
          cnt       <= cnt + CW'(1);
`ifdef SERIAL_SUB_OVF_EN
          // The borrow produced by bit WIDTH-2 is the one entering the MSB stage.
          if (cnt == CW'(WIDTH - 2)) borrow_msb <= new_borrow;
`endif
          if (last_bit) begin
            DIFF  <= res_next;
            B_out <= new_borrow;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            cnt   <= '0;
            state <= FIN;
`ifdef SERIAL_SUB_OVF_EN
            OVF   <= borrow_msb ^ new_borrow;
`endif
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8): reset, basic timing, borrow cases,
// back-to-back with START held, mid-operation reset, and optional overflow flag.
`timescale 1ns/1ps
module tb_serial_sub;
  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic [WIDTH-1:0] X = '0;
  logic [WIDTH-1:0] Y = '0;
  logic             B_in = 1'b0;
  logic [WIDTH-1:0] DIFF;
  logic             B_out, BUSY, DONE;
`ifdef SERIAL_SUB_OVF_EN
  logic             OVF;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .X(X), .Y(Y), .B_in(B_in),
    .DIFF(DIFF), .B_out(B_out), .BUSY(BUSY), .DONE(DONE)
`ifdef SERIAL_SUB_OVF_EN
    , .OVF(OVF)
`endif
  );

  always #5 CLK = ~CLK;

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Launch one operation and wait (bounded) for DONE; lat = edges from accept to DONE, -1 on timeout.
  task automatic run_op(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                        input logic bv, output int lat);
    X = xv; Y = yv; B_in = bv; START = 1'b1;
    tick();
    START = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (DONE === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({DIFF, B_out, BUSY, DONE} !== 11'd0)
      $display("FAIL reset_outputs: got %h required 0", {DIFF, B_out, BUSY, DONE});
    else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
    n_checks++;
    if (OVF !== 1'b0) $display("FAIL reset_ovf: got %b required 0", OVF);
    else n_pass++;
`endif
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int bad = 0;
    X = 8'h5A; Y = 8'h3C; B_in = 1'b0; START = 1'b1;
    tick();                        // edge 0 accepts
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (BUSY !== 1'b1 || DONE !== 1'b0 || DIFF !== 8'h00) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) $display("FAIL basic_run_window: got %0d bad cycles required 0", bad);
    else n_pass++;
    n_checks++;
    if ({BUSY, DONE} !== 2'b01) $display("FAIL basic_done_edge8: got busy/done %b required 01", {BUSY, DONE});
    else n_pass++;
    n_checks++;
    if ({DIFF, B_out} !== {8'h1E, 1'b0}) $display("FAIL basic_result: got %h/%b required 1e/0", DIFF, B_out);
    else n_pass++;
    tick();
    n_checks++;
    if ({DONE, DIFF} !== {1'b0, 8'h1E}) $display("FAIL basic_done_pulse: got done=%b diff=%h required 0/1e", DONE, DIFF);
    else n_pass++;
  endtask

  task automatic test_borrow();
    int lat;
    run_op(8'h00, 8'h01, 1'b0, lat);
    n_checks++;
    if (lat !== 8) $display("FAIL borrow1_latency: got %0d required 8", lat);
    else n_pass++;
    n_checks++;
    if ({DIFF, B_out} !== {8'hFF, 1'b1}) $display("FAIL borrow1_result: got %h/%b required ff/1", DIFF, B_out);
    else n_pass++;
    tick();
    run_op(8'h10, 8'h0F, 1'b1, lat);
    n_checks++;
    if ({DIFF, B_out} !== {8'h00, 1'b0} || lat !== 8)
      $display("FAIL borrow2_result: got %h/%b lat %0d required 00/0 lat 8", DIFF, B_out, lat);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] xa [3] = '{8'h33, 8'hFF, 8'h7E};
    logic [WIDTH-1:0] ya [3] = '{8'h44, 8'hFF, 8'h7F};
    logic             ba [3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] ed [3] = '{8'hEF, 8'h00, 8'hFE};
    logic             eb [3] = '{1'b1, 1'b0, 1'b1};
    int lat;
    X = xa[0]; Y = ya[0]; B_in = ba[0]; START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();                      // accept edge
      n_checks++;
      if ({BUSY, DONE} !== 2'b10) $display("FAIL b2b_accept%0d: got busy/done %b required 10", i, {BUSY, DONE});
      else n_pass++;
      X = 8'($urandom); Y = 8'($urandom); B_in = 1'($urandom);  // ignored while busy
      lat = -1;
      for (int j = 1; j <= 8; j++) begin
        tick();
        if (DONE === 1'b1 && lat < 0) lat = j;
      end
      n_checks++;
      if (lat !== 8 || DIFF !== ed[i] || B_out !== eb[i])
        $display("FAIL b2b_op%0d: got %h/%b lat %0d required %h/%b lat 8", i, DIFF, B_out, lat, ed[i], eb[i]);
      else n_pass++;
      if (i < 2) begin
        X = xa[i+1]; Y = ya[i+1]; B_in = ba[i+1];
      end else begin
        START = 1'b0;
      end
    end
    tick();
    n_checks++;
    if ({BUSY, DONE} !== 2'b00) $display("FAIL b2b_idle: got busy/done %b required 00", {BUSY, DONE});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    int lat;
    X = 8'hAA; Y = 8'h11; B_in = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    RST = 1'b1;
    #1;
    n_checks++;
    if ({DIFF, B_out, BUSY, DONE} !== 11'd0)
      $display("FAIL midreset_outputs: got %h required 0", {DIFF, B_out, BUSY, DONE});
    else n_pass++;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (DONE !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL midreset_no_done: got %0d bad cycles required 0", bad);
    else n_pass++;
    run_op(8'hFF, 8'h01, 1'b0, lat);
    n_checks++;
    if ({DIFF, B_out} !== {8'hFE, 1'b0} || lat !== 8)
      $display("FAIL midreset_fresh: got %h/%b lat %0d required fe/0 lat 8", DIFF, B_out, lat);
    else n_pass++;
    tick();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat;
    run_op(8'h80, 8'h01, 1'b0, lat);
    n_checks++;
    if ({DIFF, B_out, OVF} !== {8'h7F, 1'b0, 1'b1} || lat !== 8)
      $display("FAIL ovf_set: got %h/%b/%b required 7f/0/1", DIFF, B_out, OVF);
    else n_pass++;
    tick();
    run_op(8'h05, 8'h03, 1'b0, lat);
    n_checks++;
    if ({DIFF, B_out, OVF} !== {8'h02, 1'b0, 1'b0} || lat !== 8)
      $display("FAIL ovf_clear: got %h/%b/%b required 02/0/0", DIFF, B_out, OVF);
    else n_pass++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
